// File: rtl/inst_queue_pkg.sv
// Shared types and defaults for the fetch-to-decode instruction queue.
package inst_queue_pkg;

  localparam int ADDR_WIDTH      = 32;
  localparam int INST_Q_DEPTH    = 4;
  localparam int INST_Q_AF_LEVEL = 1;

  // One buffered fetch result: the pc travels with its instruction word.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [31:0]           data;
  } inst_q_entry_t;

endpackage

// File: rtl/inst_queue_if.sv
// Head-of-queue view handed to the decoder: valid flag plus the pc/instruction pair.
interface inst_q_output_ifc;
  import inst_queue_pkg::*;

  logic                  valid;
  logic [ADDR_WIDTH-1:0] pc;
  logic [31:0]           data;

  // The queue drives the head entry; the decoder only observes it.
  modport master (output valid, output pc, output data);
  modport slave  (input  valid, input  pc, input  data);

endinterface

// File: rtl/inst_queue.sv
// Instruction queue between i-cache return and decode. Circular buffer of
// {pc, data} pairs with registered outputs, stall-held head and redirect flush.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH    = INST_Q_DEPTH,
  parameter int AF_LEVEL = INST_Q_AF_LEVEL
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  input  logic [31:0]           i_data,
  output logic                  o_ready,
  output logic                  o_almost_full,
  input  logic                  i_stall,
  input  logic                  i_flush,
  inst_q_output_ifc.master      out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  inst_q_entry_t    mem_q [DEPTH];

  logic push;
  logic pop;

  // Everything the outside world sees is derived from registered state only,
  // so fetch and decode never see a combinational path through the queue.
  assign o_ready       = (count_q != CNT_W'(DEPTH));
  assign o_almost_full = ((CNT_W'(DEPTH) - count_q) <= CNT_W'(AF_LEVEL));
  assign out.valid     = (count_q != '0);
  assign out.pc        = mem_q[rdPtr_q].pc;
  assign out.data      = mem_q[rdPtr_q].data;

  // A redirect wins over everything: the instruction presented in the flush
  // cycle is stale and must not enter, and the head must not be consumed.
  assign push = i_valid & o_ready & ~i_flush;
  assign pop  = out.valid & ~i_stall & ~i_flush;

  // Next-state pointers and occupancy; flush empties the queue in one edge.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (i_flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (push) begin
        wrPtr_d = wrPtr_q + PTR_W'(1);
      end
      if (pop) begin
        rdPtr_d = rdPtr_q + PTR_W'(1);
      end
      count_d = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end
  end

  // Pointer and count registers; reset discards any queued entries.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset: contents are only observed while counted valid.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wrPtr_q] <= '{pc: i_pc, data: i_data};
    end
  end

  // Occupancy sanity: never write into a full queue, never consume from an empty one.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && !o_ready));
      assert (!(pop && !out.valid));
      assert (count_q <= CNT_W'(DEPTH));
    end
  end

endmodule
